// File: rtl/mul_spi_master_if.sv
// Shared SPI bus between the multiply-offload master and its slaves.
//   nss  : active-low slave selects, one per slave
//   mosi : master-to-slave serial data
//   miso : slave-to-master serial data
// All signalling is on the system clock; there is no separate SCK.
interface mul_spi_master_if #(
    parameter int NssWidth = 4
);
    logic [NssWidth-1:0] nss;
    logic                mosi;
    logic                miso;

    modport master (output nss, output mosi, input miso);
    modport slave  (input nss, input mosi, output miso);
endinterface

// File: rtl/mul_spi_master.sv
// SPI master that offloads a multiply to a multiplier slave.
// A request is serialised as a 2N-bit packet {op_2, op_1}, LSB first, after a
// one-cycle start marker. The master then waits for the slave's ready marker
// (miso=1) and shifts in the N-bit product, LSB first.
//
// Ports:
//   i_clock, i_reset        : system clock, synchronous active-high reset
//   i_start                 : request a multiply (accepted only when idle)
//   i_op_1, i_op_2          : operands (packet low / high half)
//   i_slave_sel             : index of the target slave's nss bit
//   o_busy                  : high whenever not idle
//   o_done                  : one-cycle pulse, o_result valid
//   o_error                 : one-cycle pulse, timeout or bad slave index
//   o_result                : last received product, held between transfers
//   spi                     : nss / mosi / miso bus (master side)
module mul_spi_master #(
    parameter int RegisterSize  = 32,   // core register width
    parameter int NssWidth      = 4,
    parameter int TimeoutCycles = 64,
    // One bit wider than a bare index so out-of-range selects reach the
    // block and are rejected instead of silently aliasing onto a real slave.
    localparam int SelWidth     = $clog2(NssWidth) + 1
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [RegisterSize-1:0] i_op_1,
    input  logic [RegisterSize-1:0] i_op_2,
    input  logic [SelWidth-1:0]     i_slave_sel,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [RegisterSize-1:0] o_result,
    mul_spi_master_if.master        spi
);
    localparam int PktW    = 2 * RegisterSize;
    localparam int BitCntW = $clog2(PktW);
    localparam int TmoW    = $clog2(TimeoutCycles + 1);

    localparam logic [SelWidth-1:0] SEL_LIMIT = SelWidth'(NssWidth);
    localparam logic [BitCntW-1:0]  SEND_LAST = BitCntW'(PktW - 1);
    localparam logic [BitCntW-1:0]  RECV_LAST = BitCntW'(RegisterSize - 1);
    localparam logic [TmoW-1:0]     TMO_LAST  = TmoW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_START, S_SEND, S_WAIT, S_RECV, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [PktW-1:0]         pkt_q;
    logic [SelWidth-1:0]     sel_q;
    logic [BitCntW-1:0]      bit_cnt_q;
    logic [TmoW-1:0]         tmo_cnt_q;
    logic [RegisterSize-1:0] rx_q, rx_next, result_q;
    logic                    err_q;

    logic sel_ok, tmo_hit, selected;

    assign sel_ok  = (i_slave_sel < SEL_LIMIT);
    // Received bits enter at the MSB so the first (LSB) bit lands at bit 0
    // after N shifts.
    assign rx_next = {spi.miso, (RegisterSize-1)'(rx_q >> 1)};

    // Next state. miso wins over the timeout if both land on the same cycle,
    // which keeps o_done and o_error mutually exclusive.
    always_comb begin
        state_d = state_q;
        tmo_hit = 1'b0;
        case (state_q)
            S_IDLE:   if (i_start && sel_ok) state_d = S_SELECT;
            S_SELECT: state_d = S_START;
            S_START:  state_d = S_SEND;
            S_SEND:   if (bit_cnt_q == SEND_LAST) state_d = S_WAIT;
            S_WAIT: begin
                if (spi.miso) begin
                    state_d = S_RECV;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RECV:   if (bit_cnt_q == RECV_LAST) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            pkt_q     <= '0;
            sel_q     <= '0;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            rx_q      <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        pkt_q <= {i_op_2, i_op_1};
                        sel_q <= i_slave_sel;
                        err_q <= !sel_ok;
                    end
                end
                S_SEND: begin
                    pkt_q <= pkt_q >> 1;
                    if (bit_cnt_q == SEND_LAST) begin
                        bit_cnt_q <= '0;
                        tmo_cnt_q <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                S_WAIT: tmo_cnt_q <= tmo_cnt_q + 1'b1;
                S_RECV: begin
                    rx_q <= rx_next;
                    if (bit_cnt_q == RECV_LAST) begin
                        bit_cnt_q <= '0;
                        result_q  <= rx_next;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs are decoded from registered state only.
    assign selected = (state_q == S_SELECT) || (state_q == S_START) ||
                      (state_q == S_SEND)   || (state_q == S_WAIT)  ||
                      (state_q == S_RECV);

    always_comb begin
        for (int i = 0; i < NssWidth; i++) begin
            spi.nss[i] = !(selected && (sel_q == SelWidth'(i)));
        end
    end

    always_comb begin
        spi.mosi = 1'b0;
        case (state_q)
            S_START: spi.mosi = 1'b1;
            S_SEND:  spi.mosi = pkt_q[0];
            default: spi.mosi = 1'b0;
        endcase
    end

    assign o_busy   = (state_q != S_IDLE);
    assign o_done   = (state_q == S_DONE);
    assign o_error  = err_q | tmo_hit;
    assign o_result = result_q;
endmodule

// File: tb/tb_mul_spi_master.sv
module tb_mul_spi_master;
    localparam int N   = 8;
    localparam int NSS = 4;
    localparam int TMO = 16;
    localparam int SW  = $clog2(NSS) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start;
    logic [N-1:0]  op1, op2, result;
    logic [SW-1:0] sel;
    logic          busy, done, err;

    mul_spi_master_if #(.NssWidth(NSS)) bus();

    mul_spi_master #(.RegisterSize(N), .NssWidth(NSS), .TimeoutCycles(TMO)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start),
        .i_op_1(op1), .i_op_2(op2), .i_slave_sel(sel),
        .o_busy(busy), .o_done(done), .o_error(err), .o_result(result),
        .spi(bus.master)
    );

    // Behavioural multiplier slave on nss[2]: start marker, 2N packet bits,
    // one operate cycle, ready marker, then N product bits LSB first.
    logic [2:0]     s_st;
    logic [4:0]     s_cnt;
    logic [2*N-1:0] s_pkt;
    logic [N-1:0]   s_res;
    logic           s_miso;

    always @(posedge clk) begin
        if (rst || bus.nss[2]) begin
            s_st <= 0; s_cnt <= 0; s_miso <= 0;
        end else begin
            case (s_st)
                0: if (bus.mosi) begin s_st <= 1; s_cnt <= 0; end
                1: begin
                    s_pkt[s_cnt[3:0]] <= bus.mosi;
                    s_cnt <= s_cnt + 1;
                    if (s_cnt == 5'(2*N-1)) s_st <= 2;
                end
                2: begin
                    s_res  <= N'(s_pkt[N-1:0] * s_pkt[2*N-1:N]);
                    s_miso <= 1; s_cnt <= 0; s_st <= 3;
                end
                3: begin
                    s_miso <= s_res[s_cnt[2:0]];
                    s_cnt  <= s_cnt + 1;
                    if (s_cnt == 5'(N)) begin s_miso <= 0; s_st <= 4; end
                end
                default: ;
            endcase
        end
    end
    assign bus.miso = bus.nss[2] ? 1'b0 : s_miso;

    int n_chk = 0, n_err = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Per-cycle logs, index = cycle number after the accept edge.
    logic [NSS-1:0] nss_log [0:63];
    logic           mosi_log[0:63];
    logic           busy_log[0:63];
    int d_cyc, e_cyc, both;

    // Present a start for one cycle, then watch ncyc cycles. At cycle poke,
    // a 9*9 request on slave 2 is pulsed (0 = no poke).
    task automatic run_txn(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [SW-1:0] s, input int ncyc, input int poke);
        op1 = a; op2 = b; sel = s; start = 1'b1;
        d_cyc = 0; e_cyc = 0; both = 0;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            start = (c == poke);
            if (c == poke) begin op1 = 9; op2 = 9; sel = 2; end
            nss_log[c]  = bus.nss;
            mosi_log[c] = bus.mosi;
            busy_log[c] = busy;
            if (done && d_cyc == 0) d_cyc = c;
            if (err && e_cyc == 0) e_cyc = c;
            if (done && err) both++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]  a, b;
        logic [SW-1:0] s;
        int            exp_done;   // cycle of o_done, 0 = never
        int            exp_err;    // cycle of o_error, 0 = never
        logic [N-1:0]  exp_res;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int bad;
        logic [7:0] bits;

        vecs[0] = '{8'd5,   8'd7,   3'd2, 29, 0,  8'd35};
        vecs[1] = '{8'd200, 8'd3,   3'd2, 29, 0,  8'h58};
        vecs[2] = '{8'd0,   8'hAB,  3'd2, 29, 0,  8'h00};
        vecs[3] = '{8'hFF,  8'hFF,  3'd2, 29, 0,  8'h01};
        vecs[4] = '{8'd13,  8'd11,  3'd2, 29, 0,  8'h8F};
        vecs[5] = '{8'd3,   8'd4,   3'd1, 0,  34, 8'h8F};  // no slave: timeout
        vecs[6] = '{8'd5,   8'd7,   3'd5, 0,  1,  8'h8F};  // index out of range
        vecs[7] = '{8'd5,   8'd7,   3'd4, 0,  1,  8'h8F};  // index == NssWidth

        rst = 1'b1; start = 1'b0; op1 = '0; op2 = '0; sel = '0;
        repeat (3) tick();
        check("reset busy",   32'(busy), 0);
        check("reset done",   32'(done), 0);
        check("reset error",  32'(err), 0);
        check("reset result", 32'(result), 0);
        check("reset nss",    32'(bus.nss), 32'hF);
        check("reset mosi",   32'(bus.mosi), 0);
        rst = 1'b0;
        tick();

        // Bus profile of 5*7 on slave 2.
        run_txn(8'd5, 8'd7, 3'd2, 30, 0);
        bad = 0;
        for (int c = 1; c <= 28; c++) if (nss_log[c] !== 4'b1011) bad++;
        check("profile nss select window", bad, 0);
        check("profile nss at done", 32'(nss_log[29]), 32'hF);
        check("profile mosi select", 32'(mosi_log[1]), 0);
        check("profile mosi start",  32'(mosi_log[2]), 1);
        for (int k = 0; k < 8; k++) bits[k] = mosi_log[3+k];
        check("profile mosi op_1 bits", 32'(bits), 32'h05);
        for (int k = 0; k < 8; k++) bits[k] = mosi_log[11+k];
        check("profile mosi op_2 bits", 32'(bits), 32'h07);
        check("profile done cycle", d_cyc, 29);
        check("profile result", 32'(result), 35);
        check("profile busy in done", 32'(busy_log[29]), 1);
        check("profile busy after",   32'(busy_log[30]), 0);

        // Vector table.
        foreach (vecs[i]) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].s, 36, 0);
            check($sformatf("vec%0d done cycle", i),  d_cyc, vecs[i].exp_done);
            check($sformatf("vec%0d error cycle", i), e_cyc, vecs[i].exp_err);
            check($sformatf("vec%0d result", i), 32'(result), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d done&error", i), both, 0);
            tick();
        end

        // Timeout: nss released and master idle after the error pulse.
        run_txn(8'd3, 8'd4, 3'd1, 36, 0);
        check("timeout nss in wait", 32'(nss_log[20]), 32'hD);
        check("timeout nss after",   32'(nss_log[35]), 32'hF);
        check("timeout busy after",  32'(busy_log[35]), 0);
        check("timeout error cycle", e_cyc, 34);

        // Bad index: never leaves idle, never selects.
        run_txn(8'd5, 8'd7, 3'd5, 10, 0);
        bad = 0;
        for (int c = 1; c <= 10; c++) if (busy_log[c] !== 1'b0 || nss_log[c] !== 4'hF) bad++;
        check("bad index stays idle", bad, 0);

        // Back-to-back: second start in the cycle after DONE.
        run_txn(8'd200, 8'd3, 3'd2, 29, 0);
        check("b2b first done", d_cyc, 29);
        check("b2b first result", 32'(result), 32'h58);
        tick();
        run_txn(8'hFF, 8'hFF, 3'd2, 29, 0);
        check("b2b second done", d_cyc, 29);
        check("b2b second result", 32'(result), 32'h01);
        tick();

        // Reset in the middle of SEND, then a clean transfer.
        run_txn(8'd5, 8'd7, 3'd2, 11, 0);
        tick();
        rst = 1'b1;
        tick();
        check("midreset nss",    32'(bus.nss), 32'hF);
        check("midreset mosi",   32'(bus.mosi), 0);
        check("midreset busy",   32'(busy), 0);
        check("midreset result", 32'(result), 0);
        rst = 1'b0;
        tick();
        run_txn(8'd5, 8'd7, 3'd2, 30, 0);
        check("post-reset done", d_cyc, 29);
        check("post-reset result", 32'(result), 35);
        tick();

        // Start while busy is ignored.
        run_txn(8'd5, 8'd7, 3'd2, 32, 20);
        check("busy-start done", d_cyc, 29);
        check("busy-start result", 32'(result), 35);
        check("busy-start no new txn", 32'(busy_log[31]), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
